// File: rtl/alu_result_latch.sv
// alu_result_latch: freezes the 8-bit ALU result on a debounced push-button press.
// The held value is shown on LEDR and on two seven-segment digits, and captures are counted modulo 16.
// Optional history register: define ALU_HISTORY_EN to build Prev and drive PrevOut from it.
module alu_result_latch #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       Clock,
    input  logic       Reset_b,
    input  logic [7:0] ALUOut,
    input  logic       Capture_n,
    output logic [7:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic       Valid,
    output logic [3:0] CaptureCount,
    output logic [7:0] PrevOut
);

    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sync_q, sync_d;
    logic [7:0]       result_q, result_d;
    logic             valid_q, valid_d;
    logic [3:0]       count_q, count_d;
    logic             key_s;
    logic             capture;

`ifdef ALU_HISTORY_EN
    logic [7:0]       prev_q, prev_d;
`endif

    // Active-low standard hex glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    assign key_s = sync_q[1];

    // Next-state logic: synchronizer shift, debounce FSM, and the single-edge capture actions.
    always_comb begin
        sync_d   = {sync_q[0], Capture_n};
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        valid_d  = valid_q;
        count_d  = count_q;
        capture  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!key_s) begin
                    state_d = DEB_PRESS;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            DEB_PRESS: begin
                if (key_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    capture = 1'b1;
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (key_s) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = CNT_ONE;
                end
            end
            DEB_RELEASE: begin
                if (!key_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (capture) begin
            result_d = ALUOut;
            valid_d  = 1'b1;
            count_d  = count_q + 4'd1;
        end
    end

`ifdef ALU_HISTORY_EN
    // History: remember the value being replaced whenever a new capture lands.
    always_comb begin
        prev_d = prev_q;
        if (capture) begin
            prev_d = result_q;
        end
    end
`endif

    // State registers; synchronous reset wins over any capture on the same edge.
    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sync_q   <= 2'b11;
            result_q <= 8'h00;
            valid_q  <= 1'b0;
            count_q  <= 4'h0;
`ifdef ALU_HISTORY_EN
            prev_q   <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sync_q   <= sync_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
`ifdef ALU_HISTORY_EN
            prev_q   <= prev_d;
`endif
        end
    end

    assign LEDR         = result_q;
    assign Valid        = valid_q;
    assign CaptureCount = count_q;
    assign HEX0         = valid_q ? seg7(result_q[3:0]) : 7'b1111111;
    assign HEX1         = valid_q ? seg7(result_q[7:4]) : 7'b1111111;

`ifdef ALU_HISTORY_EN
    assign PrevOut = prev_q;
`else
    assign PrevOut = 8'h00;
`endif

endmodule

// File: tb/tb_alu_result_latch.sv
// Testbench for alu_result_latch with DEBOUNCE_CYCLES = 4.
// A run-length reference model predicts every capture and queues it; a monitor pops and compares.
// Build with ALU_HISTORY_EN defined to also check the PrevOut history register.
module tb_alu_result_latch;

    localparam int DEB = 4;

    logic       clock;
    logic       reset_b;
    logic [7:0] alu_out;
    logic       capture_n;
    logic [7:0] LEDR;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic       Valid;
    logic [3:0] CaptureCount;
    logic [7:0] PrevOut;

    alu_result_latch #(.DEBOUNCE_CYCLES(DEB)) dut (
        .Clock        (clock),
        .Reset_b      (reset_b),
        .ALUOut       (alu_out),
        .Capture_n    (capture_n),
        .LEDR         (LEDR),
        .HEX0         (HEX0),
        .HEX1         (HEX1),
        .Valid        (Valid),
        .CaptureCount (CaptureCount),
        .PrevOut      (PrevOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         edge_no;
        logic [7:0] res;
        logic [3:0] cnt;
        logic [7:0] prev;
    } cap_t;

    cap_t sb[$];

    int pass_count  = 0;
    int check_count = 0;

    // Reference model state: debounced level, run length of the opposite level, held outputs.
    int         edge_no  = 0;
    logic [1:0] dly      = 2'b11;
    bit         pressed  = 0;
    int         run      = 0;
    logic [7:0] held_m   = 8'h00;
    logic [7:0] prev_m   = 8'h00;
    logic       valid_m  = 1'b0;
    logic [3:0] count_m  = 4'h0;
    bit         rst_flag = 0;

    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic [34:0] dut_vec;
    assign dut_vec = {LEDR, HEX1, HEX0, Valid, CaptureCount, PrevOut};

    localparam logic [34:0] RESET_VEC = {8'h00, 7'h7F, 7'h7F, 1'b0, 4'h0, 8'h00};

    function automatic logic [7:0] prev_exp();
`ifdef ALU_HISTORY_EN
        return prev_m;
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [6:0] hex_exp(input logic v, input logic [3:0] nib);
        return v ? glyph[nib] : 7'b1111111;
    endfunction

    function automatic logic [34:0] exp_vec();
        return {held_m, hex_exp(valid_m, held_m[7:4]), hex_exp(valid_m, held_m[3:0]),
                valid_m, count_m, prev_exp()};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end else begin
            pass_count++;
        end
    endtask

    // Drive inputs for n clock edges; returns at the falling edge after the last one.
    task automatic applyStimulus(input logic capn, input logic [7:0] alu, input bit rnd, input int n);
        for (int k = 0; k < n; k++) begin
            capture_n = capn;
            alu_out   = rnd ? 8'($urandom) : alu;
            @(negedge clock);
        end
    endtask

    task automatic applyReset(input logic capn);
        reset_b   = 1'b0;
        capture_n = capn;
        @(negedge clock);
        reset_b   = 1'b1;
    endtask

    // Reference model: a press/release is accepted after DEB consecutive samples of the new level
    // on the button as seen two edges late through the synchronizer.
    initial begin
        logic key;
        bit   want;
        cap_t e;
        forever begin
            @(posedge clock);
            edge_no++;
            if (!reset_b) begin
                dly      = 2'b11;
                pressed  = 0;
                run      = 0;
                held_m   = 8'h00;
                prev_m   = 8'h00;
                valid_m  = 1'b0;
                count_m  = 4'h0;
                rst_flag = 1;
                sb.delete();
            end else begin
                rst_flag = 0;
                key  = dly[1];
                dly  = {dly[0], capture_n};
                want = (key == 1'b0);
                if (want != pressed) begin
                    run++;
                    if (run == DEB) begin
                        pressed = want;
                        run     = 0;
                        if (want) begin
                            prev_m    = held_m;
                            held_m    = alu_out;
                            valid_m   = 1'b1;
                            count_m   = count_m + 4'd1;
                            e.edge_no = edge_no;
                            e.res     = held_m;
                            e.cnt     = count_m;
                            e.prev    = prev_exp();
                            sb.push_back(e);
                        end
                    end
                end else begin
                    run = 0;
                end
            end
        end
    end

    // Monitor: a change of CaptureCount marks a DUT capture; it must match a queued prediction.
    initial begin
        int         mon_edge = 0;
        logic [3:0] last_count = 4'h0;
        bit         cap_dut;
        bit         cap_exp;
        cap_t       e;
        forever begin
            @(negedge clock);
            mon_edge++;
            if (rst_flag) begin
                checkOutput("reset_state", 64'(dut_vec), 64'(RESET_VEC));
                last_count = 4'h0;
            end else begin
                cap_dut = (CaptureCount != last_count);
                cap_exp = (sb.size() > 0);
                checkOutput("capture_event", 64'(cap_dut), 64'(cap_exp));
                if (cap_exp) begin
                    e = sb.pop_front();
                    checkOutput("capture_edge", 64'(mon_edge), 64'(e.edge_no));
                    checkOutput("capture_value", 64'(LEDR), 64'(e.res));
                    checkOutput("capture_count", 64'(CaptureCount), 64'(e.cnt));
                    checkOutput("capture_prev", 64'(PrevOut), 64'(e.prev));
                end
                checkOutput("held_state", 64'(dut_vec), 64'(exp_vec()));
                last_count = CaptureCount;
            end
        end
    end

    // Directed scenarios followed by randomized press/release traffic.
    initial begin
        int p;
        int r;
        reset_b   = 1'b0;
        capture_n = 1'b1;
        alu_out   = 8'h00;
        @(negedge clock);
        reset_b   = 1'b1;

        checkOutput("rst_ledr", 64'(LEDR), 64'h00);
        checkOutput("rst_hex0", 64'(HEX0), 64'h7F);
        checkOutput("rst_hex1", 64'(HEX1), 64'h7F);
        checkOutput("rst_valid", 64'(Valid), 64'h0);
        checkOutput("rst_count", 64'(CaptureCount), 64'h0);
        checkOutput("rst_prev", 64'(PrevOut), 64'h00);

        applyStimulus(1'b0, 8'h33, 0, 3);
        applyStimulus(1'b1, 8'h33, 0, 1);
        applyStimulus(1'b0, 8'h33, 0, 3);
        applyStimulus(1'b1, 8'h33, 0, 8);
        checkOutput("bounce_valid", 64'(Valid), 64'h0);
        checkOutput("bounce_hex0", 64'(HEX0), 64'h7F);
        checkOutput("bounce_hex1", 64'(HEX1), 64'h7F);
        checkOutput("bounce_count", 64'(CaptureCount), 64'h0);

        applyStimulus(1'b0, 8'h70, 0, 5);
        checkOutput("edge5_ledr", 64'(LEDR), 64'h00);
        applyStimulus(1'b0, 8'h70, 0, 1);
        checkOutput("edge6_ledr", 64'(LEDR), 64'h70);
        checkOutput("edge6_hex1", 64'(HEX1), 64'(7'b1111000));
        checkOutput("edge6_hex0", 64'(HEX0), 64'(7'b1000000));
        checkOutput("edge6_valid", 64'(Valid), 64'h1);
        checkOutput("edge6_count", 64'(CaptureCount), 64'h1);
        applyStimulus(1'b0, 8'h70, 0, 4);
        applyStimulus(1'b0, 8'h00, 0, 20);
        checkOutput("hold_ledr", 64'(LEDR), 64'h70);
        checkOutput("hold_count", 64'(CaptureCount), 64'h1);
        applyStimulus(1'b1, 8'h00, 0, 8);

        applyStimulus(1'b0, 8'h00, 0, 7);
        checkOutput("hist_ledr", 64'(LEDR), 64'h00);
`ifdef ALU_HISTORY_EN
        checkOutput("hist_prev", 64'(PrevOut), 64'h70);
`else
        checkOutput("hist_prev", 64'(PrevOut), 64'h00);
`endif
        applyStimulus(1'b1, 8'h00, 0, 8);

        applyReset(1'b1);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1, 7);
            if (i == 15) begin
                checkOutput("wrap_count15", 64'(CaptureCount), 64'd15);
            end
            if (i == 16) begin
                checkOutput("wrap_count0", 64'(CaptureCount), 64'd0);
                checkOutput("wrap_valid", 64'(Valid), 64'h1);
            end
            applyStimulus(1'b1, 8'h00, 1, 7);
        end

        applyStimulus(1'b0, 8'h5A, 0, 2);
        applyReset(1'b0);
        checkOutput("midrst_ledr", 64'(LEDR), 64'h00);
        checkOutput("midrst_valid", 64'(Valid), 64'h0);
        checkOutput("midrst_count", 64'(CaptureCount), 64'h0);
        checkOutput("midrst_hex0", 64'(HEX0), 64'h7F);
        applyStimulus(1'b0, 8'h5A, 0, 5);
        checkOutput("midrst_nocap", 64'(Valid), 64'h0);
        applyStimulus(1'b0, 8'h5A, 0, 1);
        checkOutput("midrst_cap_valid", 64'(Valid), 64'h1);
        checkOutput("midrst_cap_ledr", 64'(LEDR), 64'h5A);
        checkOutput("midrst_cap_count", 64'(CaptureCount), 64'h1);
        applyStimulus(1'b1, 8'h00, 0, 8);

        for (int i = 0; i < 40; i++) begin
            p = $urandom_range(1, 10);
            r = $urandom_range(1, 10);
            applyStimulus(1'b0, 8'h00, 1, p);
            if ($urandom_range(0, 9) == 0) begin
                applyReset(1'($urandom));
            end
            applyStimulus(1'b1, 8'h00, 1, r);
        end
        applyStimulus(1'b1, 8'h00, 0, 10);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
